mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Main control FSM for the multicycle RV32I core: sequences the shared ALU, memory port,
//  instruction register, register file and immediate extender across 3-5 cycles per instr.
//  Decodes op/funct fields latched in the IR; drives all datapath enables and mux selects,
//  including immsrc for the immediate extender. Sits beside the datapath in the core top.
// PARAMETERS
//  RESET_STATE  4'd0  state entered on reset (FETCH); other values unsupported
// PORTS
//  clk        in   1   core clock; all state updates on rising edge
//  reset_n    in   1   synchronous, active-low reset
//  op         in   7   instr[6:0] from IR
//  funct3     in   3   instr[14:12]
//  funct7b5   in   1   instr[30]
//  zero       in   1   ALU result == 0
//  pcwrite    out  1   PC register enable
//  adrsrc     out  1   mem address mux: 0=PC, 1=ALUOut
//  memwrite   out  1   data memory write enable
//  irwrite    out  1   IR / OldPC enable
//  resultsrc  out  2   result mux: 00 ALUOut, 01 MemData, 10 ALUResult
//  alusrca    out  2   ALU A: 00 PC, 01 OldPC, 10 rs1
//  alusrcb    out  2   ALU B: 00 rs2, 01 ImmExt, 10 const 4
//  alucontrol out  3   000 add, 001 sub, 010 and, 011 or, 101 slt
//  immsrc     out  2   00 I, 01 S, 10 B, 11 J
//  regwrite   out  1   register file write enable
//  illegal    out  1   sticky: unsupported opcode decoded
// BEHAVIOUR
//  - State reg 4 bits; sync reset -> FETCH. While reset_n=0 all outputs forced 0.
//  - Outputs are combinational from state (Moore) except pcwrite (zero) and alucontrol/immsrc (op).
//  - FETCH:   adrsrc0 irwrite1 A00 B10 aluop00 res10 pcupdate1 -> DECODE
//  - DECODE:  A01 B01 aluop00 (branch target). Next by op:
//      0000011,0100011->MEMADR; 0110011->EXECUTER; 0010011->EXECUTEI; 1101111->JAL;
//      1100011->BEQ; any other->ERROR
//  - MEMADR:  A10 B01 aluop00; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE
//  - MEMREAD: res00 adrsrc1 -> MEMWB;  MEMWB: res01 regwrite1 -> FETCH
//  - MEMWRITE: res00 adrsrc1 memwrite1 -> FETCH
//  - EXECUTER: A10 B00 aluop10 -> ALUWB;  EXECUTEI: A10 B01 aluop10 -> ALUWB
//  - ALUWB:   res00 regwrite1 -> FETCH
//  - JAL:     A01 B10 aluop00 res00 pcupdate1 -> ALUWB (rd <= OldPC+4, PC <= target)
//  - BEQ:     A10 B00 aluop01 res00 branch1 -> FETCH
//  - ERROR:   all enables 0, illegal=1; held until reset_n=0 (no further fetch).
//  - pcwrite = pcupdate | (branch & zero); zero ignored outside BEQ.
//  - immsrc from op: 0100011->01, 1100011->10, 1101111->11, else 00.
//  - alucontrol: aluop00->000; 01->001; 10 by funct3: 000 -> 001 if (funct7b5 & op[5]) else 000;
//      010->101; 110->011; 111->010; other funct3 -> 000.
//  - Latency (cycles, FETCH to next FETCH): lw 5, sw 4, R 4, I-ALU 4, jal 4, beq 3.
//  - Reset mid-instruction: next edge -> FETCH; no write enable asserted in reset cycle.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined: adds port instret out 32, reset 0; +1 on every transition
//    from a non-FETCH state into FETCH (instruction retired); wraps 0xFFFFFFFF->0;
//    never increments in ERROR or during reset. Undefined: port and counter absent.
// TESTING
//  - reset_n=0 two cycles, then 1 -> all outputs 0 during reset; cycle 1 FETCH: irwrite=1, pcwrite=1.
//  - lw (op 0000011) -> states F,D,MEMADR,MEMREAD,MEMWB; regwrite=1 only in cycle 5, res=01.
//  - sw (op 0100011) -> immsrc=01; memwrite=1 in cycle 4 only, adrsrc=1; 4 cycles total.
//  - beq zero=1 then zero=0 -> pcwrite=1 in BEQ cycle only when zero=1; alucontrol=001.
//  - R-type sub (funct3 000, funct7b5 1) -> alucontrol=001; addi with funct7b5=1 -> 000.
//  - op 1111111 -> ERROR, illegal=1 sticky 20 cycles, no enables; reset_n=0 clears.
//  - PERF_EN: run lw,sw,beq,jal -> instret=4; force counter 0xFFFFFFFF + 1 retire -> 0.

Source files
------------

// File: rtl/mc_controller.sv
// Main control FSM of the multicycle RV32I core; sequences ALU, memory, IR and register file.
// Optional instruction-retired counter (instret port) when MC_CTRL_PERF_EN is defined.
module mc_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pcwrite,
    output logic        adrsrc,
    output logic        memwrite,
    output logic        irwrite,
    output logic [1:0]  resultsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [2:0]  alucontrol,
    output logic [1:0]  immsrc,
    output logic        regwrite,
`ifdef MC_CTRL_PERF_EN
    output logic [31:0] instret,
`endif
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;

    always_comb begin
        state_next = S_ERROR;
        case (state)
            S_FETCH:    state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    7'b0000011,
                    7'b0100011: state_next = S_MEMADR;
                    7'b0110011: state_next = S_EXECUTER;
                    7'b0010011: state_next = S_EXECUTEI;
                    7'b1101111: state_next = S_JAL;
                    7'b1100011: state_next = S_BEQ;
                    default:    state_next = S_ERROR;
                endcase
            end
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_ERROR;
        endcase
    end

    // Moore decode; everything held at zero while reset_n is low
    always_comb begin
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        regwrite  = 1'b0;
        illegal   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        immsrc    = 2'b00;
        if (reset_n) begin
            case (op)
                7'b0100011: immsrc = 2'b01;
                7'b1100011: immsrc = 2'b10;
                7'b1101111: immsrc = 2'b11;
                default:    immsrc = 2'b00;
            endcase
            case (state)
                S_FETCH: begin
                    irwrite   = 1'b1;
                    alusrcb   = 2'b10;
                    resultsrc = 2'b10;
                    pcupdate  = 1'b1;
                end
                S_DECODE: begin
                    alusrca = 2'b01;
                    alusrcb = 2'b01;
                end
                S_MEMADR: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                end
                S_MEMREAD:  adrsrc = 1'b1;
                S_MEMWB: begin
                    resultsrc = 2'b01;
                    regwrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc   = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXECUTER: begin
                    alusrca = 2'b10;
                    aluop   = 2'b10;
                end
                S_EXECUTEI: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                    aluop   = 2'b10;
                end
                S_ALUWB:    regwrite = 1'b1;
                S_JAL: begin
                    alusrca  = 2'b01;
                    alusrcb  = 2'b10;
                    pcupdate = 1'b1;
                end
                S_BEQ: begin
                    alusrca = 2'b10;
                    aluop   = 2'b01;
                    branch  = 1'b1;
                end
                S_ERROR:    illegal = 1'b1;
                default:    illegal = 1'b1;
            endcase
        end
    end

    // Subtract only for R-type with funct7b5; I-type ignores funct7b5
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    assign pcwrite = pcupdate | (branch & zero);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= state_next;
        end
    end

`ifdef MC_CTRL_PERF_EN
    // A retire is any entry into FETCH from another state; ERROR never gets there
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instret <= 32'd0;
        end else if (state != S_FETCH && state != S_ERROR && state_next == S_FETCH) begin
            instret <= instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed instruction sequences with hand-written
// per-cycle output vectors; covers instret when MC_CTRL_PERF_EN is defined.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0]  resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0]  alucontrol;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instret;
`endif

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .immsrc     (immsrc),
        .regwrite   (regwrite),
`ifdef MC_CTRL_PERF_EN
        .instret    (instret),
`endif
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        int          tag;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   tag   = 0;

    logic [16:0] act;
    assign act = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
                  alucontrol, immsrc, regwrite, illegal};

    // Field order: pcwrite adrsrc memwrite irwrite resultsrc alusrca alusrcb alucontrol immsrc regwrite illegal
    function automatic logic [16:0] mk(input bit pcw, input bit adr, input bit mw, input bit irw,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] alu,
                                       input logic [1:0] imm, input bit rw, input bit ill);
        return {pcw, adr, mw, irw, res, a, b, alu, imm, rw, ill};
    endfunction

    // Monitor: one output vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            if (act !== e.v) begin
                bad++;
                $display("FAIL out[%0d] act=%b exp=%b", e.tag, act, e.v);
            end
        end
    end

    task automatic step(input bit rn, input logic [6:0] o, input logic [2:0] f3,
                        input bit f7, input bit z, input logic [16:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        reset_n  = rn;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        x.v   = e;
        x.tag = tag;
        sbq.push_back(x);
        tag++;
    endtask

`ifdef MC_CTRL_PERF_EN
    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, a, e);
        end
    endtask
`endif

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;

        // Two reset cycles: everything forced low
        step(0, 7'd0, 3'd0, 0, 0, 17'd0);
        step(0, 7'd0, 3'd0, 0, 0, 17'd0);

        // lw: F D MEMADR MEMREAD MEMWB
        step(1, OP_LW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,0));

        // sw: F D MEMADR MEMWRITE
        step(1, OP_SW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
        step(1, OP_SW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
        step(1, OP_SW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
        step(1, OP_SW, 3'b010, 0, 0, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));

        // beq taken: zero high in DECODE must not write PC
        step(1, OP_BEQ, 3'b000, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0));
        step(1, OP_BEQ, 3'b000, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0));
        step(1, OP_BEQ, 3'b000, 0, 1, mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));

        // jal: F D JAL ALUWB
        step(1, OP_JAL, 3'b000, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b11,0,0));
        step(1, OP_JAL, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b11,0,0));
        step(1, OP_JAL, 3'b000, 0, 0, mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0));
        step(1, OP_JAL, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b11,1,0));

        // beq not taken
        step(1, OP_BEQ, 3'b000, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b10,0,0));
`ifdef MC_CTRL_PERF_EN
        chk("instret_4", instret, 32'd4);
`endif
        step(1, OP_BEQ, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0,0));
        step(1, OP_BEQ, 3'b000, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0,0));

        // R-type sub
        step(1, OP_R, 3'b000, 1, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_R, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        step(1, OP_R, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,0));
        step(1, OP_R, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

        // R-type or, and in EXECUTER only
        step(1, OP_R, 3'b110, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_R, 3'b110, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        step(1, OP_R, 3'b110, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0,0));
        step(1, OP_R, 3'b111, 0, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

        // addi with funct7b5=1 stays add; slti in a second instruction
        step(1, OP_I, 3'b000, 1, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_I, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        step(1, OP_I, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
        step(1, OP_I, 3'b000, 1, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));
        step(1, OP_I, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_I, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        step(1, OP_I, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0,0));
        step(1, OP_I, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,0));

        // lw interrupted by reset in MEMREAD: outputs low, then clean FETCH
        step(1, OP_LW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0));
        step(0, OP_LW, 3'b010, 0, 0, 17'd0);

        // sw after reset
        step(1, OP_SW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b01,0,0));
`ifdef MC_CTRL_PERF_EN
        chk("instret_rst", instret, 32'd0);
`endif
        step(1, OP_SW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0,0));
        step(1, OP_SW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0));
        step(1, OP_SW, 3'b010, 0, 0, mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b01,0,0));
`ifdef MC_CTRL_PERF_EN
        @(negedge clk);
        #1;
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
`endif

        // Unsupported opcode: ERROR sticky for 20 cycles
        step(1, OP_BAD, 3'b000, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
`ifdef MC_CTRL_PERF_EN
        chk("instret_wrap", instret, 32'd0);
`endif
        step(1, OP_BAD, 3'b000, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));
        for (int i = 0; i < 20; i++) begin
            step(1, OP_BAD, 3'b000, 0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1));
        end
`ifdef MC_CTRL_PERF_EN
        chk("instret_err", instret, 32'd0);
`endif
        step(0, OP_LW, 3'b010, 0, 0, 17'd0);
        step(1, OP_LW, 3'b010, 0, 0, mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,2'b00,0,0));
        step(1, OP_LW, 3'b010, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0,0));

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain act=%0d exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
